// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: pair word field
// positions and the decoder FSM state encoding.
package rle_pkg;

  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 8;
  localparam int SYM_MSB = 7;
  localparam int SYM_LSB = 0;
  localparam int SYM_W   = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    EXPAND = 3'd3,
    DONE   = 3'd4
  } rle_state_t;

endpackage

// File: rtl/rle_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset so the visible output starts at zero;
// the array itself is never cleared.
module rle_dp_ram #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands {count, symbol} pairs held in an input RAM
// into a symbol stream written to an output RAM, readable on port B.
module rle_decoder
  import rle_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic              start,
  input  logic [ADDR_W:0]   num_pairs,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] read_data_b,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   out_len,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam int PAIR_W = CNT_W + SYM_W;

  rle_state_t state, state_nxt;

  logic [ADDR_W-1:0] p;
  logic [ADDR_W:0]   n_lat;
  logic [ADDR_W:0]   n_clamp;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_load;
  logic [SYM_W-1:0]  sym;
  logic [SYM_W-1:0]  sym_out;
  logic [PAIR_W-1:0] pair_q;
  logic              is_last;
  logic              full;
  logic              in_we;
  logic [ADDR_W-1:0] in_raddr;
  logic              out_we;
  logic [ADDR_W-1:0] out_waddr;
  logic              unused_wdata;

  // Upper half of the pair word carries no information
  assign unused_wdata = ^write_data_a[DATA_W-1:PAIR_W];

  assign n_clamp  = (num_pairs > DEPTH_L) ? DEPTH_L : num_pairs;
  assign cnt_load = pair_q[CNT_MSB:CNT_LSB];
  assign is_last  = ({1'b0, p} == (n_lat - 1'b1));
  assign full     = (out_len == DEPTH_L);

  rle_dp_ram #(.ADDR_W(ADDR_W), .WIDTH(PAIR_W)) u_in_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (in_we),
    .waddr (addr_a),
    .wdata (write_data_a[PAIR_W-1:0]),
    .raddr (in_raddr),
    .rdata (pair_q)
  );

  rle_dp_ram #(.ADDR_W(ADDR_W), .WIDTH(SYM_W)) u_out_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (out_we),
    .waddr (out_waddr),
    .wdata (sym),
    .raddr (addr_b),
    .rdata (sym_out)
  );

  assign read_data_b = {{(DATA_W-SYM_W){1'b0}}, sym_out};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_clamp == '0) ? DONE : FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD: begin
        if (cnt_load == '0) state_nxt = is_last ? DONE : FETCH;
        else                state_nxt = EXPAND;
      end
      EXPAND: begin
        if (full)                    state_nxt = DONE;
        else if (cnt == CNT_W'(1))   state_nxt = is_last ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: status, RAM port control and input read-address mux
  always_comb begin
    busy      = (state != IDLE);
    in_we     = write_enable_a && (state == IDLE);
    in_raddr  = (state != IDLE) ? p : addr_a;
    out_we    = (state == EXPAND) && !full;
    out_waddr = out_len[ADDR_W-1:0];
  end

  // Decode control registers: pair index, run counter, length, flags
  always_ff @(posedge clk) begin
    if (rst) begin
      p        <= '0;
      n_lat    <= '0;
      cnt      <= '0;
      out_len  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            p        <= '0;
            n_lat    <= n_clamp;
            out_len  <= '0;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          cnt <= cnt_load;
          if (cnt_load == '0 && !is_last) p <= p + 1'b1;
        end
        EXPAND: begin
          if (full) begin
            overflow <= 1'b1;
          end else begin
            out_len <= out_len + 1'b1;
            cnt     <= cnt - 1'b1;
            if (cnt == CNT_W'(1) && !is_last) p <= p + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Symbol of the current run, captured with its count
  always_ff @(posedge clk) begin
    if (state == LOAD) sym <= pair_q[SYM_MSB:SYM_LSB];
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: a reference expander fills a
// scoreboard queue of symbols, which is drained against the output RAM.
module tb_rle_decoder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              write_enable_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] write_data_a;
  logic              start;
  logic [ADDR_W:0]   num_pairs;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] read_data_b;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   out_len;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int pc[$];
  int ps[$];

  rle_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .write_enable_a (write_enable_a),
    .addr_a         (addr_a),
    .write_data_a   (write_data_a),
    .start          (start),
    .num_pairs      (num_pairs),
    .addr_b         (addr_b),
    .read_data_b    (read_data_b),
    .busy           (busy),
    .done           (done),
    .out_len        (out_len),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pairs();
    for (int i = 0; i < pc.size(); i++) begin
      write_enable_a = 1'b1;
      addr_a         = ADDR_W'(i);
      write_data_a   = {16'hDEAD, 8'(pc[i]), 8'(ps[i])};
      tick();
    end
    write_enable_a = 1'b0;
  endtask

  // Reference expander: symbol stream, cycle of the done pulse, overflow flag
  task automatic build_expected(output int exp_cyc, output int exp_len, output bit exp_ovf);
    int cyc;
    exp_q.delete();
    exp_ovf = 1'b0;
    cyc = 1;
    for (int i = 0; i < pc.size() && !exp_ovf; i++) begin
      cyc += 2 + pc[i];
      for (int c = 0; c < pc[i] && !exp_ovf; c++) begin
        if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(ps[i]);
      end
    end
    exp_cyc = exp_ovf ? -1 : cyc;
    exp_len = exp_q.size();
  endtask

  task automatic run_decode(input string name, input int n);
    int exp_cyc, exp_len, cyc;
    bit exp_ovf;
    build_expected(exp_cyc, exp_len, exp_ovf);
    start     = 1'b1;
    num_pairs = (ADDR_W+1)'(n);
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < TMO) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) begin
      check({name, "_timeout"}, 32'(done), 32'd1);
    end else begin
      if (exp_cyc >= 0) check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      check({name, "_out_len"}, 32'(out_len), 32'(exp_len));
      check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
    for (int i = 0; i < exp_len; i++) begin
      addr_b = ADDR_W'(i);
      tick();
      check({name, "_sym"}, read_data_b, 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    bit seen;
    rst            = 1'b1;
    write_enable_a = 1'b0;
    addr_a         = '0;
    write_data_a   = '0;
    start          = 1'b0;
    num_pairs      = '0;
    addr_b         = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_len", 32'(out_len), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_read_data", read_data_b, 32'd0);
    rst = 1'b0;
    tick();

    pc = {3, 2, 1}; ps = {5, 7, 9};
    load_pairs();
    run_decode("t1_decimal", 3);

    pc = {2, 2, 1}; ps = {'o7, 'o10, 'o12};
    load_pairs();
    run_decode("t2_octal", 3);

    pc = {0, 3, 1}; ps = {'hA, 'hF, 'h1};
    load_pairs();
    run_decode("t3_zero_run", 3);

    pc = {}; ps = {};
    run_decode("t4_empty", 0);
    addr_b = '0;
    tick();
    check("t4_no_write", read_data_b, 32'hF);

    pc = {255, 255, 255, 255, 255}; ps = {'h3C, 'h3C, 'h3C, 'h3C, 'h3C};
    load_pairs();
    run_decode("t5_overflow", 5);
    addr_b = ADDR_W'(DEPTH - 1);
    tick();
    check("t5_last_word", read_data_b, 32'h3C);

    pc = {3, 2, 1}; ps = {5, 7, 9};
    load_pairs();
    num_pairs = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start          = 1'b1;
    write_enable_a = 1'b1;
    addr_a         = 1;
    write_data_a   = 32'h0000_0955;
    tick();
    start          = 1'b0;
    write_enable_a = 1'b0;
    check("t6_repulse_len", 32'(out_len), 32'd2);
    check("t6_repulse_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("t6_len_before_rst", 32'(out_len), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_out_len", 32'(out_len), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("t6_no_done_after_rst", 32'(seen), 32'd0);
    run_decode("t6_rerun", 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
